// File: rtl/masked_sbox_ser.sv
// masked_sbox_ser -- pushes an NBYTES-byte masked word through NSB masked
// AES S-box lanes, one NSB-byte slice per fresh-randomness handshake.
// Slices are injected from a register. A valid/index shift register tracks
// the fixed lane latency, and the results are reassembled in an output
// buffer that stays stable until the consumer accepts it.
//
// Macro SBOX_SER_CANRIGHT_EN: when defined, each lane uses the Canright
// core variant, which takes a fourth randomness bus. When undefined, each
// lane uses the Boyar-Peralta variant with three buses. The handshake and
// the FSM are the same in both builds.
//
// Ports:
//   clk, rst            clock (rising edge); asynchronous active-high reset
//   in_data/valid/ready masked input word, bit b of byte k, share s at
//                       (8*k+b)*d+s
//   rnd_data/valid/ready  randomness for one slice (NSB*RND_W bits)
//   out_data/valid/ready  masked S-box output word, same layout as in_data
//   busy                word in flight (FEED or DRAIN)

// One masked S-box lane with a fixed SB_LAT-cycle pipeline.
//   Input stage:      combinational S-box evaluation with fresh re-sharing.
//   Remaining stages: registers that pad the lane to SB_LAT cycles.
module masked_sbox_lane #(
    parameter int D       = 2,
    parameter int SB_LAT  = 4,
    parameter int RND_BUS = 8,
    parameter int RND_W   = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8*D-1:0]     sh_in,
    input  logic [RND_W-1:0]   rnd,
    output logic [8*D-1:0]     sh_out
);
    logic [SB_LAT-1:0][8*D-1:0] pipe_q, pipe_d;
    logic [8*D-1:0] stage0;
    logic [7:0]     x, acc, m;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254 (0 maps to 0), followed by the AES affine map.
    function automatic logic [7:0] aes_sbox(input logic [7:0] v);
        logic [7:0] p, r;
        p = v;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        x = '0;
        for (int b = 0; b < 8; b++)
            for (int s = 0; s < D; s++)
                x[b] = x[b] ^ sh_in[b*D+s];
        acc    = aes_sbox(x);
        stage0 = '0;
        m      = '0;
        // The first D-1 output shares are fresh masks. The last share absorbs them.
        for (int s = 0; s < D - 1; s++) begin
            m = rnd[8*s +: 8] ^ rnd[RND_BUS + 8*s +: 8] ^ rnd[2*RND_BUS + 8*s +: 8];
`ifdef SBOX_SER_CANRIGHT_EN
            m = m ^ rnd[3*RND_BUS + 8*s +: 8];
`endif
            acc = acc ^ m;
            for (int b = 0; b < 8; b++) stage0[b*D+s] = m[b];
        end
        for (int b = 0; b < 8; b++) stage0[b*D+D-1] = acc[b];
    end

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = stage0;
        for (int k = 1; k < SB_LAT; k++) pipe_d[k] = pipe_q[k-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= pipe_d;
    end

    assign sh_out = pipe_q[SB_LAT-1];
endmodule

module masked_sbox_ser #(
    parameter int d      = 2,
    parameter int NBYTES = 4,
    parameter int NSB    = 1,
    parameter int SB_LAT = 4,
`ifdef SBOX_SER_CANRIGHT_EN
    localparam int RND_W = 4 * (8 * d * (d - 1) / 2)
`else
    localparam int RND_W = 3 * (8 * d * (d - 1) / 2)
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*NBYTES*d-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NSB*RND_W-1:0]    rnd_data,
    input  logic                    rnd_valid,
    output logic                    rnd_ready,
    output logic [8*NBYTES*d-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);
    localparam int SLICES  = NBYTES / NSB;
    localparam int IDX_W   = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int SW      = NSB * 8 * d;
    localparam int RND_BUS = 8 * d * (d - 1) / 2;

    if (NBYTES % NSB != 0) begin : g_bad_nsb
        $error("NBYTES must be a multiple of NSB");
    end
    if (d < 2 || SB_LAT < 1) begin : g_bad_par
        $error("d must be >= 2 and SB_LAT >= 1");
    end

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             slice_q, slice_d;
    logic [8*NBYTES*d-1:0]        in_buf_q, in_buf_d;
    logic [8*NBYTES*d-1:0]        out_buf_q, out_buf_d;
    logic [SW-1:0]                sb_in_q, sb_in_d;
    logic [NSB*RND_W-1:0]         rnd_q, rnd_d;
    logic [SB_LAT:0]              vld_q, vld_d;
    logic [SB_LAT:0][IDX_W-1:0]   idx_q, idx_d;
    logic                         in_ready_q, in_ready_d;
    logic [SW-1:0]                sb_out;
    logic                         inject, accept;

    assign accept = (state_q == IDLE) && in_valid && in_ready_q;
    assign inject = (state_q == FEED) && rnd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            slice_q    <= '0;
            in_buf_q   <= '0;
            out_buf_q  <= '0;
            sb_in_q    <= '0;
            rnd_q      <= '0;
            vld_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slice_q    <= slice_d;
            in_buf_q   <= in_buf_d;
            out_buf_q  <= out_buf_d;
            sb_in_q    <= sb_in_d;
            rnd_q      <= rnd_d;
            vld_q      <= vld_d;
            idx_q      <= idx_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = FEED;
            FEED:  if (inject && slice_q == IDX_W'(SLICES - 1)) state_d = DRAIN;
            DRAIN: if (vld_q[SB_LAT] && idx_q[SB_LAT] == IDX_W'(SLICES - 1)) state_d = DONE;
            DONE:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state. Idle and bubble cycles feed all-zero shares
    // so that no stale shares reach the lane.
    always_comb begin
        slice_d   = slice_q;
        in_buf_d  = in_buf_q;
        out_buf_d = out_buf_q;
        sb_in_d   = '0;
        rnd_d     = '0;
        vld_d     = {vld_q[SB_LAT-1:0], inject};
        idx_d     = idx_q;
        idx_d[0]  = inject ? slice_q : '0;
        for (int k = 1; k <= SB_LAT; k++) idx_d[k] = idx_q[k-1];
        if (accept) begin
            in_buf_d = in_data;
            slice_d  = '0;
        end
        if (inject) begin
            sb_in_d = in_buf_q[int'(slice_q) * SW +: SW];
            rnd_d   = rnd_data;
            slice_d = slice_q + 1'b1;
        end
        // An exiting slice is captured in any state, because early slices can
        // exit while later ones are still waiting on randomness.
        if (vld_q[SB_LAT]) out_buf_d[int'(idx_q[SB_LAT]) * SW +: SW] = sb_out;
        in_ready_d = (state_d == IDLE);
    end

    always_comb begin
        in_ready  = in_ready_q;
        rnd_ready = (state_q == FEED);
        busy      = (state_q == FEED) || (state_q == DRAIN);
        out_valid = (state_q == DONE);
        out_data  = out_buf_q;
    end

    for (genvar i = 0; i < NSB; i++) begin : g_lane
        masked_sbox_lane #(.D(d), .SB_LAT(SB_LAT), .RND_BUS(RND_BUS), .RND_W(RND_W)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .sh_in  (sb_in_q[i*8*d +: 8*d]),
            .rnd    (rnd_q[i*RND_W +: RND_W]),
            .sh_out (sb_out[i*8*d +: 8*d])
        );
    end
endmodule

// File: tb/tb_masked_sbox_ser.sv
module tb_masked_sbox_ser;
`ifdef SBOX_SER_CANRIGHT_EN
    localparam int RNDW = 32;
`else
    localparam int RNDW = 24;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sel = 1'b0;
    logic [63:0]       in_data = '0;
    logic              in_valid = 1'b0;
    logic [2*RNDW-1:0] rnd_data = '0;
    logic              rnd_valid = 1'b0;
    logic              out_ready = 1'b1;

    logic in_ready_a, rnd_ready_a, out_valid_a, busy_a;
    logic in_ready_b, rnd_ready_b, out_valid_b, busy_b;
    logic [63:0] out_data_a, out_data_b;
    logic in_ready_m, rnd_ready_m, out_valid_m, busy_m;
    logic [63:0] out_data_m;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    masked_sbox_ser #(.d(2), .NBYTES(4), .NSB(1), .SB_LAT(4)) u_a (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid & ~sel), .in_ready(in_ready_a),
        .rnd_data(rnd_data[RNDW-1:0]), .rnd_valid(rnd_valid & ~sel), .rnd_ready(rnd_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .busy(busy_a)
    );

    masked_sbox_ser #(.d(2), .NBYTES(4), .NSB(2), .SB_LAT(4)) u_b (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid & sel), .in_ready(in_ready_b),
        .rnd_data(rnd_data), .rnd_valid(rnd_valid & sel), .rnd_ready(rnd_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .busy(busy_b)
    );

    assign in_ready_m  = sel ? in_ready_b  : in_ready_a;
    assign rnd_ready_m = sel ? rnd_ready_b : rnd_ready_a;
    assign out_valid_m = sel ? out_valid_b : out_valid_a;
    assign busy_m      = sel ? busy_b      : busy_a;
    assign out_data_m  = sel ? out_data_b  : out_data_a;

    typedef struct {
        bit          sel;
        logic [31:0] in_w;
        logic [31:0] exp_w;
        logic [15:0] bub;    // bit k: rnd_valid low in the cycle ending at edge k
        int          lat;
        int          hs;
        bit          noise;  // drive in_valid with junk while the word is in flight
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] share(input logic [31:0] w);
        logic [63:0] r;
        logic [31:0] m;
        m = $urandom;
        for (int i = 0; i < 32; i++) begin
            r[2*i]   = m[i];
            r[2*i+1] = w[i] ^ m[i];
        end
        return r;
    endfunction

    function automatic logic [31:0] recomb(input logic [63:0] od);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = od[2*i] ^ od[2*i+1];
        return r;
    endfunction

    // Called #1 after a rising edge. Returns once out_valid is seen or the
    // cycle budget runs out.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int hs;
        sel       = v.sel;
        in_data   = share(v.in_w);
        in_valid  = 1'b1;
        rnd_valid = 1'b1;
        chk({tag, "_in_ready_pre"}, {63'd0, in_ready_m}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        hs  = 0;
        for (int k = 1; k <= 40; k++) begin
            rnd_valid = (k < 16) ? ~v.bub[k] : 1'b1;
            rnd_data  = (2*RNDW)'({$urandom, $urandom});
            if (v.noise && k <= 3) begin
                in_valid = 1'b1;
                in_data  = {$urandom, $urandom};
            end else begin
                in_valid = 1'b0;
            end
            if (rnd_valid && rnd_ready_m) hs++;
            @(posedge clk); #1;
            if (out_valid_m) begin
                lat = k;
                break;
            end
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'(v.lat));
        chk({tag, "_data"}, {32'd0, recomb(out_data_m)}, {32'd0, v.exp_w});
        chk({tag, "_rnd_hs"}, 64'(hs), 64'(v.hs));
    endtask

    task automatic finish_ok(input string tag);
        @(posedge clk); #1;
        chk({tag, "_in_ready_post"}, {63'd0, in_ready_m}, 64'd1);
        chk({tag, "_out_valid_post"}, {63'd0, out_valid_m}, 64'd0);
    endtask

    initial begin
        vec_t vecs[6];
        logic [63:0] snap;
        bit seen;

        vecs[0] = '{0, 32'h00010253, 32'h637C77ED, 16'h0000,  9, 4, 0};
        vecs[1] = '{0, 32'h00010253, 32'h637C77ED, 16'h000C, 11, 4, 0};
        vecs[2] = '{1, 32'h53020100, 32'hED777C63, 16'h0000,  7, 2, 0};
        vecs[3] = '{0, 32'hAA80FF10, 32'hACCD16CA, 16'h0000,  9, 4, 1};
        vecs[4] = '{1, 32'hAA80FF10, 32'hACCD16CA, 16'h0002,  8, 2, 0};
        vecs[5] = '{0, 32'h00010253, 32'h637C77ED, 16'h0002, 10, 4, 0};

        // Reset values, then in_ready rising after release.
        #3;
        chk("rst_in_ready", {63'd0, in_ready_a}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
        chk("rst_rnd_ready", {63'd0, rnd_ready_a}, 64'd0);
        chk("rst_busy", {63'd0, busy_a}, 64'd0);
        chk("rst_out_data", out_data_a, 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {63'd0, in_ready_a}, 64'd1);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            finish_ok($sformatf("vec%0d", i));
        end

        // Backpressure in DONE.
        sel = 1'b0;
        out_ready = 1'b0;
        run_vec(vecs[0], "bp");
        snap = out_data_m;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_valid%0d", c), {63'd0, out_valid_m}, 64'd1);
            chk($sformatf("bp_in_ready%0d", c), {63'd0, in_ready_m}, 64'd0);
            chk($sformatf("bp_stable%0d", c), out_data_m, snap);
        end
        out_ready = 1'b1;
        finish_ok("bp");

        // Reset in the middle of a word.
        sel = 1'b0;
        in_data = share(32'h00010253);
        in_valid = 1'b1;
        rnd_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy", {63'd0, busy_m}, 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_in_ready", {63'd0, in_ready_a}, 64'd0);
        chk("mid_out_valid", {63'd0, out_valid_a}, 64'd0);
        chk("mid_rnd_ready", {63'd0, rnd_ready_a}, 64'd0);
        chk("mid_busy_rst", {63'd0, busy_a}, 64'd0);
        chk("mid_out_data", out_data_a, 64'd0);
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (out_valid_a || out_valid_b || busy_a) seen = 1'b1;
        end
        chk("mid_no_ghost", {63'd0, seen}, 64'd0);
        chk("mid_out_data_idle", out_data_a, 64'd0);
        run_vec(vecs[3], "fresh");
        finish_ok("fresh");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
